entropy_decode_codeword: RTL

- Bitstream-side inverse of the encoder's DC/AC entropy coders.
- Consumes a packed MSB-first bitstream in 32-bit words and extracts one combined Rice/exp-Golomb codeword per handshake.
- Codebook is supplied per codeword; an optional sign unfold yields signed coefficients.
- Feeds the future DC-delta and AC run/level reconstruction stages of the decoder path.

---
 rtl/entropy_decode_codeword.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/entropy_decode_codeword.sv
// Codeword extractor for the decoder path: pulls combined Rice/exp-Golomb
// codewords out of an MSB-first 32-bit bitstream, with optional sign unfold.
module entropy_decode_codeword #(
    parameter int WORD_W = 32,
    parameter int VAL_W  = 20
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic [WORD_W-1:0] BS_DATA,
    input  logic              BS_VALID,
    output logic              BS_READY,
    input  logic [2:0]        RICE_ORDER,
    input  logic [2:0]        EXP_ORDER,
    input  logic [1:0]        SWITCH_BITS,
    input  logic              SIGNED_MODE,
    output logic              CW_VALID,
    input  logic              CW_READY,
    output logic [VAL_W-1:0]  CW_VALUE,
    output logic [5:0]        CW_LENGTH,
    output logic              ERROR
);

    localparam int BUF_W = 2 * WORD_W;

    typedef enum logic [1:0] {IDLE, FILL, HOLD, ERR} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [6:0]         fill_q, fill_d;
    logic [VAL_W-1:0]   cwValue_q, cwValue_d;
    logic [5:0]         cwLength_q, cwLength_d;

    // Decoder datapath; 40-bit code arithmetic covers the longest legal
    // exp-Golomb codeword plus the Rice offset without overflow.
    logic [4:0]         leadZeros;
    logic               oneSeen, canDecode, zeroRunBad, useRice;
    logic [6:0]         riceSuffix;
    logic [39:0]        riceCode, expCode, expBits, code;
    logic [6:0]         riceLen, expLen, expShift, codeLen;
    logic               lenBad, haveAll, rangeBad, decodeErr, decodeDone;
    logic [VAL_W-1:0]   codeLow, decodedValue;
    logic               cwTake, wordTake;
    logic [6:0]         fillAfterTake;

    // Leading-zero count over the top 16 buffer bits; 16 means no 1 seen there.
    always_comb begin
        leadZeros = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (buf_q[BUF_W-16+i]) leadZeros = 5'(15 - i);
        end
    end

    assign oneSeen    = |buf_q[BUF_W-1 -: 16];
    assign canDecode  = oneSeen || (fill_q >= 7'd16);
    assign zeroRunBad = (leadZeros == 5'd16);
    assign useRice    = (leadZeros <= {3'b000, SWITCH_BITS});

    assign riceSuffix = 7'((buf_q << (leadZeros + 5'd1)) >> (BUF_W - 7)) >> (3'd7 - RICE_ORDER);
    assign riceCode   = ({35'd0, leadZeros} << RICE_ORDER) + {33'd0, riceSuffix};
    assign riceLen    = {2'b00, leadZeros} + 7'd1 + {4'b0000, RICE_ORDER};

    assign expLen     = {4'b0000, EXP_ORDER} + {1'b0, leadZeros, 1'b0} - {5'b00000, SWITCH_BITS};
    assign expShift   = 7'(BUF_W) - expLen;
    assign expBits    = 40'(buf_q >> expShift);
    assign expCode    = expBits - (40'd1 << EXP_ORDER)
                        + (({38'd0, SWITCH_BITS} + 40'd1) << RICE_ORDER);

    assign code       = useRice ? riceCode : expCode;
    assign codeLen    = useRice ? riceLen : expLen;
    assign lenBad     = (codeLen > 7'd32);
    assign haveAll    = (codeLen <= fill_q);
    // A signed unfold of any code below 2^VAL_W always fits VAL_W bits, so one
    // bound covers both modes.
    assign rangeBad   = (code >= (40'd1 << VAL_W));
    assign decodeErr  = canDecode && (zeroRunBad || lenBad || (haveAll && rangeBad));
    assign decodeDone = canDecode && !zeroRunBad && !lenBad && haveAll && !rangeBad;

    assign codeLow      = code[VAL_W-1:0];
    assign decodedValue = SIGNED_MODE ? ((codeLow >> 1) ^ {VAL_W{codeLow[0]}}) : codeLow;

    assign cwTake        = (state_q == HOLD) && CW_READY;
    assign fillAfterTake = cwTake ? (fill_q - {1'b0, cwLength_q}) : fill_q;
    assign wordTake      = BS_VALID && BS_READY;

    // State register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; START overrides everything, including ERR and IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            FILL: begin
                if (decodeErr)       state_d = ERR;
                else if (decodeDone) state_d = HOLD;
            end
            HOLD: if (CW_READY) state_d = FILL;
            ERR:  state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (START) state_d = FILL;
    end

    // Outputs; word intake is throttled on the post-consume fill and held off during START.
    always_comb begin
        CW_VALID  = (state_q == HOLD);
        ERROR     = (state_q == ERR);
        BS_READY  = ((state_q == FILL) || (state_q == HOLD)) && !START && (fillAfterTake <= 7'd32);
        CW_VALUE  = cwValue_q;
        CW_LENGTH = cwLength_q;
    end

    // Buffer update: consume the handed-off codeword, then append any accepted word below it.
    always_comb begin
        buf_d      = buf_q;
        fill_d     = fill_q;
        cwValue_d  = cwValue_q;
        cwLength_d = cwLength_q;
        if (cwTake) begin
            buf_d  = buf_q << cwLength_q;
            fill_d = fill_q - {1'b0, cwLength_q};
        end
        if (wordTake) begin
            buf_d  = buf_d | ({BS_DATA, {WORD_W{1'b0}}} >> fill_d);
            fill_d = fill_d + 7'(WORD_W);
        end
        if ((state_q == FILL) && decodeDone) begin
            cwValue_d  = decodedValue;
            cwLength_d = codeLen[5:0];
        end
        if (START) begin
            buf_d  = '0;
            fill_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            buf_q      <= '0;
            fill_q     <= '0;
            cwValue_q  <= '0;
            cwLength_q <= '0;
        end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            cwValue_q  <= cwValue_d;
            cwLength_q <= cwLength_d;
        end
    end

endmodule
